ita_ctrl_queue: RTL and testbench
=================================

# ita_ctrl_queue

Multi-context control-register queue for the ITA accelerator. Software writes one attention-layer configuration into a staging register set, commits it, and may queue further configurations while the engine runs. The engine side sees the active context's control fields, a one-cycle start pulse per context, and per-step requantisation constants selected by the current step. The block sits between the configuration bus and the ITA controller.

## Interface
- NumCtx, 2: queued contexts behind the active one (≥1).
- S, 64: maximum sequence length; seq_length field width = idx_width(S+1).
- P, 64: maximum projection space; field width = idx_width(P+1).
- E, 64: maximum embedding size; field width = idx_width(E+1).
- H, 1: maximum head count; field width = idx_width(H+1).
- NumSteps, 6: requant parameter sets (Q, K, V, QK, AV, OW).
- EMS, 8: eps_mult and right_shift width.
- WI, 8: add width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_we_i  in  1  staging write strobe.
- cfg_addr_i  in  5  word address.
- cfg_wdata_i  in  32  write data.
- cfg_commit_i  in  1  push staging set as a new context.
- done_i  in  1  engine finished active context.
- step_i  in  3  current step (0..5; 6 = Idle).
- active_o  out  1  active context valid.
- start_o  out  1  one-cycle pulse on context activation.
- seq_length_o, proj_space_o, embed_size_o, n_heads_o  out  field widths  active fields.
- lin_tiles_o, attn_tiles_o, tile_s_o, tile_e_o, tile_p_o  out  32 each  active fields.
- eps_mult_o, right_shift_o  out  EMS each  requant constants for step_i.
- add_o  out  WI  requant offset for step_i.
- pending_o  out  idx_width(NumCtx+1)  queued (not active) contexts.
- full_o  out  1  pending_o == NumCtx.
- cfg_overflow_o  out  1  pulse: commit dropped.
- cfg_err_o  out  1  pulse: write to unmapped address.

## Operation
- Register map (word addresses): 0 seq_length, 1 proj_space, 2 embed_size, 3 n_heads, 4..9 requant step k = addr-4 as {add[23:16], right_shift[15:8], eps_mult[7:0]}, 10 lin_tiles, 11 attn_tiles, 12 tile_s, 13 tile_e, 14 tile_p. Narrow fields take low bits; upper bits discarded. Addresses 15..31: no write, cfg_err_o pulses next cycle.
- Staging set persists after commit; contexts may be incrementally edited.
- Commit: snapshot staging. Same-cycle write lands in staging after the snapshot (snapshot holds old value).
- Activation priority: if no active context (or done_i this cycle): queue head becomes active; if queue empty, a same-cycle commit bypasses directly into active.
- Otherwise commit appends to the FIFO queue (circular, wrap-around on pointers).
- Commit when full_o and no done_i: dropped, cfg_overflow_o pulses, queue unchanged. Commit + done_i while full: accepted (head moves out, slot frees).
- done_i with active_o low: ignored. done_i with empty queue and no commit: active_o falls.
- step_i ≥ NumSteps: eps_mult_o, right_shift_o, add_o = 0.
- State per context: IDLE (active_o=0) → RUN on activation (start_o pulse) → RUN on done_i with next available (start_o pulse again) or IDLE otherwise.

## Timing
- Reset: all outputs 0; queue emptied; active cleared; staging zeroed. Reset mid-run discards all contexts without start_o.
- Commit at cycle t to idle empty block: active_o=1, start_o=1, fields valid at t+1.
- done_i at t with queue non-empty: next context fields + start_o at t+1; active_o stays 1 (no gap).
- step_i at t → requant outputs at t+1 (registered), from active context at t.
- pending_o/full_o, cfg_overflow_o, cfg_err_o update/pulse at t+1.

## Configuration
- ITA_CTRL_READBACK_EN: adds cfg_re_i (in, 1) and cfg_rdata_o (out, 32); cfg_re_i at t returns staging word for cfg_addr_i at t+1, zero-extended, 0 for unmapped addresses; write-then-read of same address in consecutive cycles returns new value. Without the macro the ports do not exist and staging is write-only.

## Test plan
- Write seq_length=64, step 3 word 0x00_05_7F, commit; idle → t+1 active_o=1, start_o=1, seq_length_o=64; step_i=3 → eps_mult_o=0x7F, right_shift_o=5, add_o=0 next cycle.
- NumCtx=2: commit ×4 without done_i → pending_o=2, full_o=1, 4th commit pulses cfg_overflow_o.
- Full queue, commit + done_i same cycle → accepted, pending_o stays 2, start_o pulses, no overflow.
- Write addr 20 → cfg_err_o pulse, readback of all mapped words unchanged; step_i=6 → requant outputs 0.
- Commit then done_i ×3 with queue of 2 → start_o pulses at each, active_o drops after last done_i; rst_i mid-run → all outputs 0 next cycle, no start_o.
- With ITA_CTRL_READBACK_EN: write tile_p=0xDEADBEEF, read addr 14 next cycle → cfg_rdata_o=0xDEADBEEF.

Source files
------------

// File: rtl/ita_ctrl_queue.sv
// ITA control-register queue: staging set, FIFO of committed contexts, active context and per-step requant.
// Optional staging readback port (cfg_re_i / cfg_rdata_o) is enabled by defining ITA_CTRL_READBACK_EN.
module ita_ctrl_queue #(
  parameter int unsigned NumCtx   = 2,
  parameter int unsigned S        = 64,
  parameter int unsigned P        = 64,
  parameter int unsigned E        = 64,
  parameter int unsigned H        = 1,
  parameter int unsigned NumSteps = 6,
  parameter int unsigned EMS      = 8,
  parameter int unsigned WI       = 8,
  localparam int unsigned SW  = (S + 1 > 1) ? $clog2(S + 1) : 1,
  localparam int unsigned PJW = (P + 1 > 1) ? $clog2(P + 1) : 1,
  localparam int unsigned EW  = (E + 1 > 1) ? $clog2(E + 1) : 1,
  localparam int unsigned HW  = (H + 1 > 1) ? $clog2(H + 1) : 1,
  localparam int unsigned CW  = (NumCtx + 1 > 1) ? $clog2(NumCtx + 1) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cfg_we_i,
  input  logic [4:0]     cfg_addr_i,
  input  logic [31:0]    cfg_wdata_i,
  input  logic           cfg_commit_i,
  input  logic           done_i,
  input  logic [2:0]     step_i,
  output logic           active_o,
  output logic           start_o,
  output logic [SW-1:0]  seq_length_o,
  output logic [PJW-1:0] proj_space_o,
  output logic [EW-1:0]  embed_size_o,
  output logic [HW-1:0]  n_heads_o,
  output logic [31:0]    lin_tiles_o,
  output logic [31:0]    attn_tiles_o,
  output logic [31:0]    tile_s_o,
  output logic [31:0]    tile_e_o,
  output logic [31:0]    tile_p_o,
  output logic [EMS-1:0] eps_mult_o,
  output logic [EMS-1:0] right_shift_o,
  output logic [WI-1:0]  add_o,
  output logic [CW-1:0]  pending_o,
  output logic           full_o,
  output logic           cfg_overflow_o,
`ifdef ITA_CTRL_READBACK_EN
  input  logic           cfg_re_i,
  output logic [31:0]    cfg_rdata_o,
`endif
  output logic           cfg_err_o
);

  localparam int unsigned PW = (NumCtx > 1) ? $clog2(NumCtx) : 1;

  typedef struct packed {
    logic [WI-1:0]  add;
    logic [EMS-1:0] rs;
    logic [EMS-1:0] em;
  } rq_t;

  typedef struct packed {
    logic [SW-1:0]  seq;
    logic [PJW-1:0] proj;
    logic [EW-1:0]  emb;
    logic [HW-1:0]  heads;
    logic [31:0]    lin;
    logic [31:0]    attn;
    logic [31:0]    ts;
    logic [31:0]    te;
    logic [31:0]    tp;
    rq_t [NumSteps-1:0] rq;
  } ctx_t;

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  ctx_t           stg_q, stg_d;
  ctx_t           act_q, act_d;
  ctx_t           mem_q [NumCtx];
  logic [PW-1:0]  rd_q, wr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  rq_t            rq_q;
  logic           start_q, ovf_q, err_q, err_d;
  logic           done_eff, take, pop, byp, push, ovf;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NumCtx - 1)) ? '0 : p + 1'b1;
  endfunction

  // Staging write decode; requant words occupy addresses 4..4+NumSteps-1.
  always_comb begin
    logic hit;
    stg_d = stg_q;
    hit   = 1'b1;
    case (cfg_addr_i)
      5'd0:  stg_d.seq   = cfg_wdata_i[SW-1:0];
      5'd1:  stg_d.proj  = cfg_wdata_i[PJW-1:0];
      5'd2:  stg_d.emb   = cfg_wdata_i[EW-1:0];
      5'd3:  stg_d.heads = cfg_wdata_i[HW-1:0];
      5'd10: stg_d.lin   = cfg_wdata_i;
      5'd11: stg_d.attn  = cfg_wdata_i;
      5'd12: stg_d.ts    = cfg_wdata_i;
      5'd13: stg_d.te    = cfg_wdata_i;
      5'd14: stg_d.tp    = cfg_wdata_i;
      default: begin
        hit = 1'b0;
        for (int k = 0; k < NumSteps; k++) begin
          if (cfg_addr_i == 5'(k + 4)) begin
            hit = 1'b1;
            stg_d.rq[k].em  = cfg_wdata_i[EMS-1:0];
            stg_d.rq[k].rs  = cfg_wdata_i[8 +: EMS];
            stg_d.rq[k].add = cfg_wdata_i[16 +: WI];
          end
        end
      end
    endcase
    if (!cfg_we_i) stg_d = stg_q;
    err_d = cfg_we_i && !hit;
  end

  // Queue head has priority over a same-cycle commit; commit bypasses only into an empty queue.
  always_comb begin
    done_eff = done_i && (state_q == RUN);
    take     = (state_q == IDLE) || done_eff;
    pop      = take && (cnt_q != '0);
    byp      = take && (cnt_q == '0) && cfg_commit_i;
    push     = cfg_commit_i && !byp && ((cnt_q != CW'(NumCtx)) || pop);
    ovf      = cfg_commit_i && !byp && !push;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    act_d    = pop ? mem_q[rd_q] : (byp ? stg_q : act_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop || byp) state_d = RUN;
      RUN:     if (done_eff && !(pop || byp)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      stg_q   <= '0;
      act_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      rq_q    <= '0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NumCtx; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      start_q <= pop || byp;
      ovf_q   <= ovf;
      err_q   <= err_d;
      rq_q    <= (32'(step_i) < NumSteps) ? act_q.rq[step_i] : '0;
      if (pop) rd_q <= ptr_inc(rd_q);
      if (push) begin
        mem_q[wr_q] <= stg_q;
        wr_q        <= ptr_inc(wr_q);
      end
    end
  end

`ifdef ITA_CTRL_READBACK_EN
  logic [31:0] rdata_q;

  function automatic logic [31:0] rd_word(input ctx_t c, input logic [4:0] a);
    logic [31:0] w;
    w = '0;
    case (a)
      5'd0:  w = 32'(c.seq);
      5'd1:  w = 32'(c.proj);
      5'd2:  w = 32'(c.emb);
      5'd3:  w = 32'(c.heads);
      5'd10: w = c.lin;
      5'd11: w = c.attn;
      5'd12: w = c.ts;
      5'd13: w = c.te;
      5'd14: w = c.tp;
      default: begin
        for (int k = 0; k < NumSteps; k++)
          if (a == 5'(k + 4)) w = 32'({c.rq[k].add, c.rq[k].rs, c.rq[k].em});
      end
    endcase
    return w;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i)         rdata_q <= '0;
    else if (cfg_re_i) rdata_q <= rd_word(stg_q, cfg_addr_i);
    else               rdata_q <= '0;
  end

  assign cfg_rdata_o = rdata_q;
`endif

  always_comb begin
    active_o = (state_q == RUN);
    start_o  = start_q;
  end

  assign seq_length_o   = act_q.seq;
  assign proj_space_o   = act_q.proj;
  assign embed_size_o   = act_q.emb;
  assign n_heads_o      = act_q.heads;
  assign lin_tiles_o    = act_q.lin;
  assign attn_tiles_o   = act_q.attn;
  assign tile_s_o       = act_q.ts;
  assign tile_e_o       = act_q.te;
  assign tile_p_o       = act_q.tp;
  assign eps_mult_o     = rq_q.em;
  assign right_shift_o  = rq_q.rs;
  assign add_o          = rq_q.add;
  assign pending_o      = cnt_q;
  assign full_o         = (cnt_q == CW'(NumCtx));
  assign cfg_overflow_o = ovf_q;
  assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_ita_ctrl_queue.sv
// Directed bench for ita_ctrl_queue: commit/bypass, queue fill/overflow, done chaining, errors, reset.
module tb_ita_ctrl_queue;
  logic        clk = 1'b0;
  logic        rst, we, commit, done;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  step;
  logic        active, start, full, ovf, err;
  logic [6:0]  seq_len, proj, embed;
  logic [0:0]  heads;
  logic [31:0] lin, attn, ts, te, tp;
  logic [7:0]  em, rs, add;
  logic [1:0]  pending;
`ifdef ITA_CTRL_READBACK_EN
  logic        re;
  logic [31:0] rdata;
`endif
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ita_ctrl_queue dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
    .cfg_commit_i(commit), .done_i(done), .step_i(step),
    .active_o(active), .start_o(start), .seq_length_o(seq_len), .proj_space_o(proj),
    .embed_size_o(embed), .n_heads_o(heads), .lin_tiles_o(lin), .attn_tiles_o(attn),
    .tile_s_o(ts), .tile_e_o(te), .tile_p_o(tp), .eps_mult_o(em), .right_shift_o(rs),
    .add_o(add), .pending_o(pending), .full_o(full), .cfg_overflow_o(ovf),
`ifdef ITA_CTRL_READBACK_EN
    .cfg_re_i(re), .cfg_rdata_o(rdata),
`endif
    .cfg_err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Inputs change #1 after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; commit = 1'b0; done = 1'b0;
    addr = '0; wdata = '0; step = 3'd0;
`ifdef ITA_CTRL_READBACK_EN
    re = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_active", 32'(active), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_seq", 32'(seq_len), 0);

    // Context A: bypass into an idle block
    wr(5'd0, 32'd64);
    wr(5'd1, 32'h1FF);
    wr(5'd3, 32'd1);
    wr(5'd7, 32'h0000_057F);
    wr(5'd14, 32'hDEAD_BEEF);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("A_active", 32'(active), 1);
    chk("A_start", 32'(start), 1);
    chk("A_seq", 32'(seq_len), 64);
    chk("A_proj_trunc", 32'(proj), 32'h7F);
    chk("A_heads", 32'(heads), 1);
    chk("A_tile_p", tp, 32'hDEAD_BEEF);
    chk("A_pending", 32'(pending), 0);
    step = 3'd3;
    tick();
    chk("A_eps", 32'(em), 32'h7F);
    chk("A_rs", 32'(rs), 5);
    chk("A_add", 32'(add), 0);
    chk("A_start_pulse", 32'(start), 0);

    // Fill queue; each commit carries a same-cycle write that must not enter the snapshot
    we = 1'b1; addr = 5'd0; wdata = 32'd10;
    tick();
    commit = 1'b1; wdata = 32'd11;
    tick();
    chk("q1_pending", 32'(pending), 1);
    chk("q1_full", 32'(full), 0);
    wdata = 32'd12;
    tick();
    chk("q2_pending", 32'(pending), 2);
    chk("q2_full", 32'(full), 1);
    chk("q2_ovf", 32'(ovf), 0);
    wdata = 32'd13;
    tick();
    chk("q3_ovf", 32'(ovf), 1);
    chk("q3_pending", 32'(pending), 2);
    we = 1'b0; commit = 1'b0;
    tick();
    chk("q3_ovf_clear", 32'(ovf), 0);

    // Full queue: commit + done together is accepted
    commit = 1'b1; done = 1'b1;
    tick();
    commit = 1'b0; done = 1'b0;
    chk("fd_start", 32'(start), 1);
    chk("fd_seq", 32'(seq_len), 10);
    chk("fd_pending", 32'(pending), 2);
    chk("fd_ovf", 32'(ovf), 0);
    chk("fd_active", 32'(active), 1);

    // Unmapped write, then idle step
    wr(5'd20, 32'hFFFF_FFFF);
    chk("err_pulse", 32'(err), 1);
    tick();
    chk("err_clear", 32'(err), 0);
    chk("B_eps", 32'(em), 32'h7F);
    step = 3'd6;
    tick();
    chk("idle_eps", 32'(em), 0);
    chk("idle_rs", 32'(rs), 0);
    chk("idle_add", 32'(add), 0);

    // Drain: C(11), D(13), then idle
    done = 1'b1;
    tick();
    chk("C_start", 32'(start), 1);
    chk("C_seq", 32'(seq_len), 11);
    chk("C_pending", 32'(pending), 1);
    tick();
    chk("D_start", 32'(start), 1);
    chk("D_seq", 32'(seq_len), 13);
    chk("D_active", 32'(active), 1);
    chk("D_pending", 32'(pending), 0);
    tick();
    done = 1'b0;
    chk("drain_active", 32'(active), 0);
    chk("drain_start", 32'(start), 0);

    // Staging survived the unmapped write
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("E_start", 32'(start), 1);
    chk("E_seq", 32'(seq_len), 13);
    chk("E_proj", 32'(proj), 32'h7F);
    chk("E_tile_p", tp, 32'hDEAD_BEEF);

    // Reset mid-run
    rst = 1'b1;
    tick();
    chk("mr_active", 32'(active), 0);
    chk("mr_start", 32'(start), 0);
    chk("mr_seq", 32'(seq_len), 0);
    chk("mr_tile_p", tp, 0);
    rst = 1'b0;
    tick();
    chk("mr_start_after", 32'(start), 0);

    // done with nothing active is ignored
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("nd_active", 32'(active), 0);
    chk("nd_start", 32'(start), 0);

`ifdef ITA_CTRL_READBACK_EN
    we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; re = 1'b1;
    tick();
    chk("rb_tile_p", rdata, 32'hDEAD_BEEF);
    addr = 5'd20;
    tick();
    re = 1'b0;
    chk("rb_unmapped", rdata, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
